// File: rtl/alu_status_if.sv
// Operand/result channel between the issue logic and the execution stage;
// start is a one-cycle launch, done/reg_we are one-cycle result pulses.
interface alu_status_if;
    logic       start;
    logic [3:0] op;
    logic [7:0] src;
    logic [7:0] opd;
    logic       busy;
    logic       done;
    logic [7:0] dst;
    logic       reg_we;

    modport master (
        output start, op, src, opd,
        input  busy, done, dst, reg_we
    );

    modport slave (
        input  start, op, src, opd,
        output busy, done, dst, reg_we
    );
endinterface

// File: rtl/alu_status.sv
// ALU + processor status register P: result/flags one cycle after start, two for decimal ADC/SBC.
// No ready signal: start is dropped while busy (decimal adjust cycle), accepted in every IDLE cycle.
module alu_status #(
    parameter logic [7:0] P_RESET = 8'h34
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_status_if.slave  bus,
    input  logic         p_load,
    input  logic [7:0]   p_in,
    input  logic         flag_we,
    input  logic [1:0]   flag_sel,
    input  logic         flag_val,
    output logic [7:0]   P
);

    localparam logic [3:0] OP_ORA  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_EOR  = 4'h2;
    localparam logic [3:0] OP_ADC  = 4'h3;
    localparam logic [3:0] OP_PASS = 4'h4;
    localparam logic [3:0] OP_CMP  = 4'h5;
    localparam logic [3:0] OP_SBC  = 4'h6;
    localparam logic [3:0] OP_BIT  = 4'h7;
    localparam logic [3:0] OP_ASL  = 4'h8;
    localparam logic [3:0] OP_ROL  = 4'h9;
    localparam logic [3:0] OP_LSR  = 4'hA;
    localparam logic [3:0] OP_ROR  = 4'hB;
    localparam logic [3:0] OP_INC  = 4'hC;
    localparam logic [3:0] OP_DEC  = 4'hD;

    typedef enum logic {IDLE, DADJ} state_t;

    state_t      state_q, state_d;
    logic [7:0]  p_q, p_d;
    logic [7:0]  dst_q;
    logic        done_q;
    logic        reg_we_q;

    // binary sum and carries held across the decimal adjust cycle
    logic [7:0]  bin_q;
    logic        bin_c_q;
    logic        hc_q;
    logic        v_q;
    logic        sbc_q;

    logic [7:0]  b_eff;
    logic [8:0]  sum9;
    logic [8:0]  cmp9;
    logic [7:0]  alu_res;
    logic        alu_wr, alu_tnz, alu_tc, alu_tv;
    logic        alu_n, alu_z, alu_c, alu_v, alu_hc;
    logic        is_arith;

    logic [8:0]  dec_t;
    logic        dec_c;

    logic        fire, cap_en;
    logic [7:0]  fin_res;
    logic        fin_wr, fin_tnz, fin_tc, fin_tv;
    logic        fin_n, fin_z, fin_c, fin_v;

    always_comb begin : alu_bin
        b_eff    = (bus.op == OP_SBC) ? ~bus.opd : bus.opd;
        sum9     = {1'b0, bus.src} + {1'b0, b_eff} + {8'd0, p_q[0]};
        cmp9     = {1'b0, bus.src} + {1'b0, ~bus.opd} + 9'd1;
        // carry into bit 4 is the nibble half-carry
        alu_hc   = bus.src[4] ^ b_eff[4] ^ sum9[4];
        is_arith = (bus.op == OP_ADC) || (bus.op == OP_SBC);
        alu_res  = bus.src;
        alu_wr   = 1'b0;
        alu_tnz  = 1'b0;
        alu_tc   = 1'b0;
        alu_tv   = 1'b0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (bus.op)
            OP_ORA:  begin alu_res = bus.src | bus.opd; alu_wr = 1'b1; alu_tnz = 1'b1; end
            OP_AND:  begin alu_res = bus.src & bus.opd; alu_wr = 1'b1; alu_tnz = 1'b1; end
            OP_EOR:  begin alu_res = bus.src ^ bus.opd; alu_wr = 1'b1; alu_tnz = 1'b1; end
            OP_PASS: begin alu_res = bus.opd;           alu_wr = 1'b1; alu_tnz = 1'b1; end
            OP_ADC, OP_SBC: begin
                alu_res = sum9[7:0];
                alu_wr  = 1'b1;
                alu_tnz = 1'b1;
                alu_tc  = 1'b1;
                alu_tv  = 1'b1;
                alu_c   = sum9[8];
                alu_v   = ~(bus.src[7] ^ b_eff[7]) & (bus.src[7] ^ sum9[7]);
            end
            OP_CMP: begin
                alu_res = cmp9[7:0];
                alu_tnz = 1'b1;
                alu_tc  = 1'b1;
                alu_c   = cmp9[8];
            end
            OP_BIT: begin
                alu_tnz = 1'b1;
                alu_tv  = 1'b1;
                alu_v   = bus.opd[6];
            end
            OP_ASL: begin
                alu_res = {bus.src[6:0], 1'b0};
                alu_wr = 1'b1; alu_tnz = 1'b1; alu_tc = 1'b1; alu_c = bus.src[7];
            end
            OP_ROL: begin
                alu_res = {bus.src[6:0], p_q[0]};
                alu_wr = 1'b1; alu_tnz = 1'b1; alu_tc = 1'b1; alu_c = bus.src[7];
            end
            OP_LSR: begin
                alu_res = {1'b0, bus.src[7:1]};
                alu_wr = 1'b1; alu_tnz = 1'b1; alu_tc = 1'b1; alu_c = bus.src[0];
            end
            OP_ROR: begin
                alu_res = {p_q[0], bus.src[7:1]};
                alu_wr = 1'b1; alu_tnz = 1'b1; alu_tc = 1'b1; alu_c = bus.src[0];
            end
            OP_INC: begin alu_res = bus.src + 8'd1; alu_wr = 1'b1; alu_tnz = 1'b1; end
            OP_DEC: begin alu_res = bus.src - 8'd1; alu_wr = 1'b1; alu_tnz = 1'b1; end
            default: ;
        endcase
        alu_n = alu_res[7];
        alu_z = (alu_res == 8'h00);
        if (bus.op == OP_BIT) begin
            alu_n = bus.opd[7];
            alu_z = ((bus.src & bus.opd) == 8'h00);
        end
    end

    always_comb begin : dec_adjust
        dec_t = {1'b0, bin_q};
        dec_c = bin_c_q;
        if (!sbc_q) begin
            if ((bin_q[3:0] > 4'd9) || hc_q)
                dec_t = dec_t + 9'd6;
            if ((dec_t[8:4] > 5'd9) || bin_c_q) begin
                dec_t = dec_t + 9'h060;
                dec_c = 1'b1;
            end
        end else begin
            if (!hc_q)
                dec_t = dec_t - 9'd6;
            if (!bin_c_q)
                dec_t = dec_t - 9'h060;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin : fsm_next
        state_d = state_q;
        cap_en  = 1'b0;
        fire    = 1'b0;
        fin_res = alu_res;
        fin_wr  = alu_wr;
        fin_tnz = alu_tnz;
        fin_tc  = alu_tc;
        fin_tv  = alu_tv;
        fin_n   = alu_n;
        fin_z   = alu_z;
        fin_c   = alu_c;
        fin_v   = alu_v;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_arith && p_q[3]) begin
                        state_d = DADJ;
                        cap_en  = 1'b1;
                    end else begin
                        fire = 1'b1;
                    end
                end
            end
            DADJ: begin
                state_d = IDLE;
                fire    = 1'b1;
                fin_res = dec_t[7:0];
                fin_wr  = 1'b1;
                fin_tnz = 1'b1;
                fin_tc  = 1'b1;
                fin_tv  = 1'b1;
                fin_n   = dec_t[7];
                fin_z   = (dec_t[7:0] == 8'h00);
                fin_c   = dec_c;
                fin_v   = v_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // flag_we first, ALU flags on top, p_load wins outright
    always_comb begin : p_next
        p_d = p_q;
        if (flag_we) begin
            case (flag_sel)
                2'd0: p_d[0] = flag_val;
                2'd1: p_d[2] = flag_val;
                2'd2: p_d[3] = flag_val;
                2'd3: p_d[6] = flag_val;
                default: ;
            endcase
        end
        if (fire) begin
            if (fin_tnz) begin
                p_d[7] = fin_n;
                p_d[1] = fin_z;
            end
            if (fin_tc)
                p_d[0] = fin_c;
            if (fin_tv)
                p_d[6] = fin_v;
        end
        if (p_load)
            p_d = p_in;
        p_d[5:4] = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q      <= P_RESET;
            dst_q    <= 8'h00;
            done_q   <= 1'b0;
            reg_we_q <= 1'b0;
            bin_q    <= 8'h00;
            bin_c_q  <= 1'b0;
            hc_q     <= 1'b0;
            v_q      <= 1'b0;
            sbc_q    <= 1'b0;
        end else begin
            p_q      <= p_d;
            done_q   <= fire;
            reg_we_q <= fire && fin_wr;
            if (fire && fin_wr)
                dst_q <= fin_res;
            if (cap_en) begin
                bin_q   <= alu_res;
                bin_c_q <= alu_c;
                hc_q    <= alu_hc;
                v_q     <= alu_v;
                sbc_q   <= (bus.op == OP_SBC);
            end
        end
    end

    assign bus.busy   = (state_q == DADJ);
    assign bus.done   = done_q;
    assign bus.dst    = dst_q;
    assign bus.reg_we = reg_we_q;
    assign P          = p_q | 8'h30;

endmodule

// File: tb/tb_alu_status.sv
// Bench for alu_status: integer-level reference model checked every cycle, plus pinned literals.
module tb_alu_status;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       p_load, flag_we, flag_val;
    logic [7:0] p_in;
    logic [1:0] flag_sel;
    logic [7:0] P;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int m_p, m_dst, n_p, n_dst;
    bit m_done, m_we, m_busy, nx_done, nx_we, nx_busy;
    int pa, pb, pc;
    bit psbc;

    always #5 clk = ~clk;

    alu_status_if bus ();

    alu_status #(.P_RESET(8'h34)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .p_load   (p_load),
        .p_in     (p_in),
        .flag_we  (flag_we),
        .flag_sel (flag_sel),
        .flag_val (flag_val),
        .P        (P)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sg(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic bit ovf(input int s);
        return (s > 127) || (s < -128);
    endfunction

    function automatic int setb(input int v, input int pos, input bit val);
        return val ? (v | (1 << pos)) : (v & ~(1 << pos));
    endfunction

    function automatic int bcd2i(input int x);
        return (x >> 4) * 10 + (x & 15);
    endfunction

    function automatic int i2bcd(input int x);
        return ((x / 10) << 4) | (x % 10);
    endfunction

    task automatic model_reset();
        m_p = 8'h34; m_dst = 0; m_done = 0; m_we = 0; m_busy = 0;
    endtask

    task automatic model_step();
        int a, b, c, r, s, op, fn, fz, fc, fv;
        bit tnz, tc, tv, wr;
        n_p = m_p; n_dst = m_dst; nx_done = 0; nx_we = 0; nx_busy = 0;
        tnz = 0; tc = 0; tv = 0; wr = 0; fc = 0; fv = 0; r = 0;
        a = int'(bus.src); b = int'(bus.opd); c = m_p & 1; op = int'(bus.op);
        fn = -1; fz = -1;
        if (flag_we) begin
            case (flag_sel)
                2'd0: n_p = setb(n_p, 0, flag_val);
                2'd1: n_p = setb(n_p, 2, flag_val);
                2'd2: n_p = setb(n_p, 3, flag_val);
                default: n_p = setb(n_p, 6, flag_val);
            endcase
        end
        if (m_busy) begin
            if (!psbc) begin
                s = bcd2i(pa) + bcd2i(pb) + pc;
                fc = (s >= 100); r = i2bcd(s % 100);
                fv = ovf(sg(pa) + sg(pb) + pc);
            end else begin
                s = bcd2i(pa) - bcd2i(pb) - (1 - pc);
                fc = (s >= 0); if (s < 0) s += 100; r = i2bcd(s);
                fv = ovf(sg(pa) - sg(pb) - (1 - pc));
            end
            nx_done = 1; wr = 1; tnz = 1; tc = 1; tv = 1;
        end else if (bus.start) begin
            if ((op == 3 || op == 6) && (m_p & 8) != 0) begin
                pa = a; pb = b; pc = c; psbc = (op == 6); nx_busy = 1;
            end else begin
                nx_done = 1;
                case (op)
                    0: begin r = a | b; wr = 1; tnz = 1; end
                    1: begin r = a & b; wr = 1; tnz = 1; end
                    2: begin r = a ^ b; wr = 1; tnz = 1; end
                    3: begin s = a + b + c; r = s & 255; fc = (s > 255); fv = ovf(sg(a) + sg(b) + c);
                             wr = 1; tnz = 1; tc = 1; tv = 1; end
                    4: begin r = b; wr = 1; tnz = 1; end
                    5: begin r = (a - b) & 255; fc = (a >= b); tnz = 1; tc = 1; end
                    6: begin s = a - b - (1 - c); r = s & 255; fc = (s >= 0); fv = ovf(sg(a) - sg(b) - (1 - c));
                             wr = 1; tnz = 1; tc = 1; tv = 1; end
                    7: begin fz = ((a & b) == 0); fn = (b >> 7) & 1; fv = (b >> 6) & 1; tnz = 1; tv = 1; end
                    8: begin r = (a << 1) & 255; fc = a >> 7; wr = 1; tnz = 1; tc = 1; end
                    9: begin r = ((a << 1) | c) & 255; fc = a >> 7; wr = 1; tnz = 1; tc = 1; end
                    10: begin r = a >> 1; fc = a & 1; wr = 1; tnz = 1; tc = 1; end
                    11: begin r = (a >> 1) | (c << 7); fc = a & 1; wr = 1; tnz = 1; tc = 1; end
                    12: begin r = (a + 1) & 255; wr = 1; tnz = 1; end
                    13: begin r = (a + 255) & 255; wr = 1; tnz = 1; end
                    default: ;
                endcase
            end
        end
        if (fn < 0) fn = (r >> 7) & 1;
        if (fz < 0) fz = (r == 0);
        if (nx_done) begin
            if (tnz) begin n_p = setb(n_p, 7, fn[0]); n_p = setb(n_p, 1, fz[0]); end
            if (tc) n_p = setb(n_p, 0, fc[0]);
            if (tv) n_p = setb(n_p, 6, fv[0]);
            if (wr) begin n_dst = r; nx_we = 1; end
        end
        if (p_load) n_p = int'(p_in);
        n_p = (n_p | 8'h30) & 255;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        m_p = n_p; m_dst = n_dst; m_done = nx_done; m_we = nx_we; m_busy = nx_busy;
        @(negedge clk);
    endtask

    task automatic do_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1; bus.op = o; bus.src = a; bus.opd = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic set_flag(input logic [1:0] s, input logic v);
        flag_we = 1'b1; flag_sel = s; flag_val = v;
        tick();
        flag_we = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dst",    int'(bus.dst),    m_dst);
            chk("done",   int'(bus.done),   int'(m_done));
            chk("reg_we", int'(bus.reg_we), int'(m_we));
            chk("busy",   int'(bus.busy),   int'(m_busy));
            chk("P",      int'(P),          m_p);
        end
    end

    logic [19:0] vec [15];

    initial begin
        bus.start = 1'b0; bus.op = 4'h0; bus.src = 8'h00; bus.opd = 8'h00;
        p_load = 1'b0; p_in = 8'h00; flag_we = 1'b0; flag_sel = 2'd0; flag_val = 1'b0;
        vec = '{20'h0F00F, 20'h1F03C, 20'h2FF5A, 20'h88100, 20'h94000,
                20'hA0100, 20'hB0200, 20'h73FC0, 20'h37F01, 20'h650F0,
                20'h50510, 20'hE1234, 20'hF0000, 20'hC7F00, 20'h40000};
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_P",      int'(P),          8'h34);
        chk("rst_done",   int'(bus.done),   0);
        chk("rst_busy",   int'(bus.busy),   0);
        chk("rst_reg_we", int'(bus.reg_we), 0);
        chk("rst_dst",    int'(bus.dst),    0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        do_op(4'h3, 8'h50, 8'h50);
        chk("adc_bin_dst",  int'(bus.dst),    8'hA0);
        chk("adc_bin_we",   int'(bus.reg_we), 1);
        chk("adc_bin_P",    int'(P),          8'hF4);

        set_flag(2'd2, 1'b1);
        do_op(4'h3, 8'h19, 8'h28);
        chk("dec_busy",     int'(bus.busy),   1);
        chk("dec_nodone",   int'(bus.done),   0);
        tick();
        chk("dec_dst",      int'(bus.dst),    8'h47);
        chk("dec_P",        int'(P),          8'h3C);
        do_op(4'h3, 8'h99, 8'h01);
        tick();
        chk("dec99_dst",    int'(bus.dst),    8'h00);
        chk("dec99_P",      int'(P),          8'h3F);

        set_flag(2'd2, 1'b0);
        do_op(4'h4, 8'h00, 8'h5A);
        do_op(4'h5, 8'h10, 8'h10);
        chk("cmp_we",       int'(bus.reg_we), 0);
        chk("cmp_dst",      int'(bus.dst),    8'h5A);
        chk("cmp_P",        int'(P),          8'h37);
        do_op(4'hC, 8'hFF, 8'h00);
        chk("inc_dst",      int'(bus.dst),    8'h00);
        chk("inc_done",     int'(bus.done),   1);

        p_load = 1'b1; p_in = 8'h00;
        do_op(4'hB, 8'h01, 8'h00);
        p_load = 1'b0;
        chk("pload_P",      int'(P),          8'h30);
        chk("pload_dst",    int'(bus.dst),    8'h80);
        chk("pload_we",     int'(bus.reg_we), 1);

        for (int i = 0; i < 15; i++)
            do_op(vec[i][19:16], vec[i][15:8], vec[i][7:0]);
        set_flag(2'd3, 1'b0);
        set_flag(2'd1, 1'b0);
        set_flag(2'd1, 1'b1);
        do_op(4'hD, 8'h00, 8'h00);
        chk("dec_wrap_dst", int'(bus.dst),    8'hFF);

        set_flag(2'd2, 1'b1);
        set_flag(2'd0, 1'b1);
        do_op(4'h6, 8'h42, 8'h13);
        chk("abort_busy",   int'(bus.busy),   1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_P",      int'(P),          8'h34);
        chk("abort_busy0",  int'(bus.busy),   0);
        rst_n = 1'b1;
        tick();
        chk("abort_nodone", int'(bus.done),   0);

        set_flag(2'd2, 1'b1);
        set_flag(2'd0, 1'b1);
        do_op(4'h6, 8'h42, 8'h13);
        bus.start = 1'b1; bus.op = 4'hC; bus.src = 8'h10;
        tick();
        bus.start = 1'b0;
        chk("dsbc_done",    int'(bus.done),   1);
        chk("dsbc_dst",     int'(bus.dst),    8'h29);
        chk("dsbc_C",       int'(P[0]),       1);
        tick();
        chk("dsbc_one",     int'(bus.done),   0);
        chk("dsbc_hold",    int'(bus.dst),    8'h29);
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_status.md
Name: alu_status

Overview:
- Execution stage directly upstream of the register file's write port.
- Consumes the regfile `src` operand plus a second operand (memory or `idx` path) and produces `dst`/`reg_we` for the regfile.
- Owns the processor status register P (N V 1 B D I Z C).
- Binary ops complete in one cycle. Decimal-mode ADC/SBC take one extra adjust cycle, matching 65C02 timing.

Parameters:
- P_RESET, 8'h34, status register value after reset (I=1, bits 5 and 4 set, D=0).

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch operation; `op`/`src`/`opd` are sampled only in this cycle
- op  input  4  operation code, see Behaviour
- src  input  8  first operand, from regfile `src`
- opd  input  8  second operand (data bus or `idx`)
- busy  output  1  high while in DADJ; `start` is ignored while high
- done  output  1  one-cycle pulse: result and flags are valid
- dst  output  8  result to regfile `dst`; held until the next done
- reg_we  output  1  equals done AND the op writes a register
- p_load  input  1  load P from `p_in` (PLP/RTI)
- p_in  input  8  value for p_load; bits 5 and 4 are forced to 1
- flag_we  input  1  single-flag write (CLC/SEC/CLI/SEI/CLD/SED/CLV)
- flag_sel  input  2  flag select: 0=C 1=I 2=D 3=V
- flag_val  input  1  value to write
- P  output  8  status register {N,V,1,1,D,I,Z,C}

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; P=P_RESET.
  - dst=0, done=0, reg_we=0, busy=0.
  - A reset asserted in DADJ aborts the operation: no done, no flag change.
- States:
  - IDLE: start with a binary op or D=0 → result registered at that edge; done=1 in the next cycle; stay in IDLE.
  - IDLE: start with ADC/SBC and D=1 → the binary sum and binary V are registered; go to DADJ; busy=1.
  - DADJ: apply the decimal adjust; done=1 in the next cycle; return to IDLE.
- start is accepted in any IDLE cycle, including the cycle done is high, so back-to-back ops give one result per cycle. start in DADJ is dropped.
- Op codes, 8-bit wrap-around arithmetic ("wr" = writes a register):
  - 0 ORA: src|opd, NZ, wr
  - 1 AND: src&opd, NZ, wr
  - 2 EOR: src^opd, NZ, wr
  - 3 ADC: src+opd+C, NZVC, wr
  - 4 PASS: opd, NZ, wr
  - 5 CMP: src-opd; C=(src>=opd unsigned), N, Z; no write
  - 6 SBC: src+~opd+C, NZVC, wr
  - 7 BIT: Z=((src&opd)==0), N=opd[7], V=opd[6]; no write; dst unchanged
  - 8 ASL: C=src[7]
  - 9 ROL: shift in C, C=src[7]
  - A LSR: C=src[0], N=0
  - B ROR: shift in C, C=src[0]
  - ASL/ROL/LSR/ROR all update NZC and write.
  - C INC: src+1, NZ, wr
  - D DEC: src-1, NZ, wr
  - E, F reserved: done pulses; no write, no flag change, dst unchanged.
- V rule for ADC/SBC: V=(~(a^b)&(a^r))[7], where b=opd for ADC and b=~opd for SBC.
- Decimal ADC:
  - Low nibble >9 or half-carry → add 6.
  - High result >9 or binary carry → add 0x60 and set C=1.
- Decimal SBC:
  - Half-borrow → subtract 6.
  - Borrow (binary C=0) → subtract 0x60; C is the binary no-borrow.
- Decimal flags: N and Z come from the adjusted result; V is the binary V.
- Flag update priority at an edge: p_load > ALU completion > flag_we.
  - Flags not touched by the winner keep their value.
  - ALU flags are committed at the edge that raises done.
  - flag_we to D during DADJ takes effect after the current op (the adjust uses the D captured at start).
- P bits 5 and 4 always read 1.

Test Plan:
- Reset → P=8'h34, done=0, busy=0, reg_we=0, dst=0.
- D=0, C=0: ADC src=8'h50 opd=8'h50 → done one cycle later; dst=8'hA0, reg_we=1, N=1 V=1 Z=0 C=0.
- SED, then C=0: ADC src=8'h19 opd=8'h28 → busy one cycle; done at +2; dst=8'h47, C=0. Then ADC 8'h99+8'h01 → dst=8'h00, C=1, Z=1.
- CMP src=8'h10 opd=8'h10 → done=1, reg_we=0, Z=1 C=1 N=0; dst keeps its previous value. Back-to-back start on the done cycle (INC src=8'hFF) → next cycle dst=8'h00, Z=1.
- p_load=1 (p_in=8'h00) together with ALU completion (ROR src=8'h01, C=1) → P=8'h30; dst=8'h80, reg_we=1.
- Decimal SBC launched; rst_n pulsed low during DADJ → no done, P=8'h34; a start in DADJ without reset → ignored, exactly one done.
